gpio_irq_sched: RTL and testbench

- Per-pin GPIO event detector and interrupt scheduler sitting between the pad-side gpio_in bus and the core event/interrupt input.
- Synchronises and glitch-filters inputs, detects configurable edge/level events on input-direction pins, and latches them as pending.
- Presents one pending pin at a time to the core via a round-robin req/ack handshake.
- Lets firmware GPIO tests (for example, a toggle on pin 4) be serviced in fair order.

---
 rtl/gpio_irq_pkg.sv | 17 +
 rtl/gpio_irq_rr_pick.sv | 33 +++
 rtl/gpio_irq_sched.sv | 141 ++++++++++++++
 tb/tb_gpio_irq_sched.sv | 308 ++++++++++++++++++++++++++++++
 4 files changed

// File: rtl/gpio_irq_pkg.sv
// Shared types for the GPIO interrupt scheduler: per-pin event types and arbiter states.
package gpio_irq_pkg;

    typedef enum logic [1:0] {
        RISE  = 2'b00,
        FALL  = 2'b01,
        BOTH  = 2'b10,
        LEVEL = 2'b11
    } irq_type_e;

    typedef enum logic [1:0] {
        IDLE = 2'b00,
        REQ  = 2'b01,
        GAP  = 2'b10
    } arb_state_e;

endpackage

// File: rtl/gpio_irq_rr_pick.sv
// Combinational round-robin pick: first set pending bit at or after ptr, wrapping
// to pin 0 after the last pin.
module gpio_irq_rr_pick
    import gpio_irq_pkg::*;
#(
    parameter int NPINS = 32,
    parameter int IDW   = $clog2(NPINS)
) (
    input  logic [NPINS-1:0] pend_i,
    input  logic [IDW-1:0]   ptr_i,
    output logic             valid_o,
    output logic [IDW-1:0]   idx_o
);

    localparam int OW = IDW + 1;

    logic [NPINS-1:0] rot_s;
    logic [OW-1:0]    off_s;
    logic [OW-1:0]    sum_s;

    // Rotate so ptr lands at bit 0, find the lowest set bit, then rotate the index back.
    always_comb begin
        rot_s   = NPINS'({pend_i, pend_i} >> ptr_i);
        valid_o = |rot_s;
        off_s   = '0;
        for (int k = NPINS - 1; k >= 0; k--) begin
            off_s = rot_s[k] ? OW'(k) : off_s;
        end
        sum_s = {1'b0, ptr_i} + off_s;
        idx_o = (sum_s >= OW'(NPINS)) ? IDW'(sum_s - OW'(NPINS)) : sum_s[IDW-1:0];
    end

endmodule

// File: rtl/gpio_irq_sched.sv
// GPIO event detector and round-robin interrupt scheduler: sync, tick-sampled glitch
// filter, per-pin edge/level events, pending latch and one-at-a-time req/ack to the core.
module gpio_irq_sched
    import gpio_irq_pkg::*;
#(
    parameter int NPINS = 32,
    parameter int IDW   = $clog2(NPINS),
    parameter int DIVW  = 16
) (
    input  logic                 clk,
    input  logic                 rst,
    input  logic [NPINS-1:0]     gpio_in_i,
    input  logic [NPINS-1:0]     gpio_dir_i,
    input  logic [NPINS-1:0]     int_en_i,
    input  logic [2*NPINS-1:0]   int_type_i,
    input  logic [DIVW-1:0]      filt_div_i,
    input  logic [NPINS-1:0]     pending_clr_i,
    output logic                 irq_o,
    output logic [IDW-1:0]       irq_id_o,
    input  logic                 irq_ack_i,
    output logic [NPINS-1:0]     pending_o,
    output logic [NPINS-1:0]     gpio_sync_o
);

    logic [NPINS-1:0] s1_q, s2_q, sample_q, filt_q, prev_q, pend_q;
    logic [NPINS-1:0] sample_d, filt_d, pend_d;
    logic [DIVW-1:0]  cnt_q, cnt_d;
    logic             tick_s;

    logic [NPINS-1:0] rise_s, fall_s, evt_s, set_s, clr_s, ack_vec_s;
    logic             ack_fire_s;

    arb_state_e       state_q;
    logic             irq_q;
    logic [IDW-1:0]   irq_id_q, ptr_q;
    logic             pick_valid_s;
    logic [IDW-1:0]   pick_idx_s;

    // Filter prescaler; a count above a freshly lowered terminal value wraps without ticking.
    always_comb begin
        tick_s = (cnt_q == filt_div_i);
        cnt_d  = (cnt_q >= filt_div_i) ? '0 : cnt_q + DIVW'(1'b1);
    end

    for (genvar i = 0; i < NPINS; i++) begin : g_pin
        irq_type_e type_s;
        assign type_s    = irq_type_e'(int_type_i[2*i +: 2]);
        assign filt_d[i] = (tick_s && (s2_q[i] == sample_q[i])) ? s2_q[i] : filt_q[i];
        assign rise_s[i] = filt_q[i] & ~prev_q[i];
        assign fall_s[i] = ~filt_q[i] & prev_q[i];
        assign evt_s[i]  = (type_s == RISE) ? rise_s[i] :
                           (type_s == FALL) ? fall_s[i] :
                           (type_s == BOTH) ? (rise_s[i] | fall_s[i]) : filt_q[i];
    end

    // Pending update; a new event wins over a same-cycle software clear or ack.
    always_comb begin
        ack_fire_s          = (state_q == REQ) & irq_ack_i;
        ack_vec_s           = '0;
        ack_vec_s[irq_id_q] = ack_fire_s;
        set_s               = evt_s & int_en_i & ~gpio_dir_i;
        clr_s               = pending_clr_i | ack_vec_s;
        pend_d              = set_s | (pend_q & ~clr_s);
        sample_d            = tick_s ? s2_q : sample_q;
    end

    // Input synchroniser, filter, edge history, pending and prescaler state.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            s1_q     <= '0;
            s2_q     <= '0;
            sample_q <= '0;
            filt_q   <= '0;
            prev_q   <= '0;
            pend_q   <= '0;
            cnt_q    <= '0;
        end else begin
            s1_q     <= gpio_in_i;
            s2_q     <= s1_q;
            sample_q <= sample_d;
            filt_q   <= filt_d;
            prev_q   <= filt_q;
            pend_q   <= pend_d;
            cnt_q    <= cnt_d;
        end
    end

    gpio_irq_rr_pick #(
        .NPINS (NPINS),
        .IDW   (IDW)
    ) u_pick (
        .pend_i  (pend_q),
        .ptr_i   (ptr_q),
        .valid_o (pick_valid_s),
        .idx_o   (pick_idx_s)
    );

    // Request arbiter; GAP plus IDLE guarantee two low cycles between requests.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state_q  <= IDLE;
            irq_q    <= 1'b0;
            irq_id_q <= '0;
            ptr_q    <= '0;
        end else begin
            case (state_q)
                IDLE: begin
                    if (pick_valid_s) begin
                        irq_id_q <= pick_idx_s;
                        irq_q    <= 1'b1;
                        state_q  <= REQ;
                    end
                end
                REQ: begin
                    if (irq_ack_i) begin
                        irq_q   <= 1'b0;
                        ptr_q   <= (irq_id_q == IDW'(NPINS - 1)) ? '0 : irq_id_q + IDW'(1'b1);
                        state_q <= GAP;
                    end else if (!pend_q[irq_id_q]) begin
                        irq_q   <= 1'b0;
                        state_q <= IDLE;
                    end
                end
                GAP: begin
                    irq_q   <= 1'b0;
                    state_q <= IDLE;
                end
                default: begin
                    irq_q   <= 1'b0;
                    state_q <= IDLE;
                end
            endcase
        end
    end

    assign irq_o       = irq_q;
    assign irq_id_o    = irq_id_q;
    assign pending_o   = pend_q;
    assign gpio_sync_o = filt_q;

endmodule

// File: tb/tb_gpio_irq_sched.sv
// Self-checking bench for gpio_irq_sched: directed scenarios plus a randomized run,
// all checked every cycle against a behavioural reference model.
module tb_gpio_irq_sched;

    localparam int NPINS = 32;
    localparam int IDW   = 5;
    localparam int DIVW  = 16;

    logic                 clk = 1'b0;
    logic                 rst;
    logic [NPINS-1:0]     gpio_in, gpio_dir, int_en, pclr;
    logic [2*NPINS-1:0]   int_type;
    logic [DIVW-1:0]      filt_div;
    logic                 ack;
    logic                 irq;
    logic [IDW-1:0]       irq_id;
    logic [NPINS-1:0]     pend, sync;

    int checks   = 0;
    int failures = 0;

    // reference model state
    bit [NPINS-1:0] m_s1, m_s2, m_samp, m_filt, m_prev, m_pend;
    int m_cnt;
    bit m_req, m_gap;
    int m_id, m_ptr;

    always #5 clk = ~clk;

    gpio_irq_sched #(.NPINS(NPINS), .IDW(IDW), .DIVW(DIVW)) dut (
        .clk           (clk),
        .rst           (rst),
        .gpio_in_i     (gpio_in),
        .gpio_dir_i    (gpio_dir),
        .int_en_i      (int_en),
        .int_type_i    (int_type),
        .filt_div_i    (filt_div),
        .pending_clr_i (pclr),
        .irq_o         (irq),
        .irq_id_o      (irq_id),
        .irq_ack_i     (ack),
        .pending_o     (pend),
        .gpio_sync_o   (sync)
    );

    task automatic check_eq(input string tag, input logic [63:0] act, input logic [63:0] exp);
        checks++;
        if (act !== exp) begin
            failures++;
            $display("FAIL %s: got %0h expected %0h at %0t", tag, act, exp, $time);
        end
    endtask

    task automatic model_reset();
        m_s1 = '0; m_s2 = '0; m_samp = '0; m_filt = '0; m_prev = '0; m_pend = '0;
        m_cnt = 0; m_req = 1'b0; m_gap = 1'b0; m_id = 0; m_ptr = 0;
    endtask

    task automatic model_step();
        bit [NPINS-1:0] n_s1, n_s2, n_samp, n_filt, n_prev, n_pend;
        bit tick, ackf, r, f, ev, clr;
        int t, p;
        tick = (m_cnt == int'(filt_div));
        ackf = m_req && ack;
        for (int i = 0; i < NPINS; i++) begin
            r = m_filt[i] && !m_prev[i];
            f = !m_filt[i] && m_prev[i];
            t = int'(int_type[2*i +: 2]);
            case (t)
                0: ev = r;
                1: ev = f;
                2: ev = r || f;
                default: ev = m_filt[i];
            endcase
            clr       = pclr[i] || (ackf && m_id == i);
            n_pend[i] = (ev && int_en[i] && !gpio_dir[i]) || (m_pend[i] && !clr);
            n_prev[i] = m_filt[i];
            n_s1[i]   = gpio_in[i];
            n_s2[i]   = m_s1[i];
            n_samp[i] = tick ? m_s2[i] : m_samp[i];
            n_filt[i] = (tick && m_s2[i] == m_samp[i]) ? m_s2[i] : m_filt[i];
        end
        if (m_req) begin
            if (ack) begin
                m_req = 1'b0; m_gap = 1'b1; m_ptr = (m_id + 1) % NPINS;
            end else if (!m_pend[m_id]) begin
                m_req = 1'b0;
            end
        end else if (m_gap) begin
            m_gap = 1'b0;
        end else begin
            for (int k = NPINS - 1; k >= 0; k--) begin
                p = (m_ptr + k) % NPINS;
                if (m_pend[p]) begin
                    m_req = 1'b1; m_id = p;
                end
            end
        end
        m_cnt  = (m_cnt >= int'(filt_div)) ? 0 : m_cnt + 1;
        m_s1 = n_s1; m_s2 = n_s2; m_samp = n_samp; m_filt = n_filt; m_prev = n_prev; m_pend = n_pend;
    endtask

    task automatic cycle();
        @(posedge clk);
        if (rst) model_reset(); else model_step();
        #1;
        check_eq("irq", 64'(irq), 64'(m_req));
        if (m_req) check_eq("irq_id", 64'(irq_id), 64'(m_id));
        check_eq("pending", 64'(pend), 64'(m_pend));
        check_eq("gpio_sync", 64'(sync), 64'(m_filt));
    endtask

    task automatic do_reset();
        gpio_in = '0; gpio_dir = '0; int_en = '0; int_type = '0;
        filt_div = '0; pclr = '0; ack = 1'b0;
        rst = 1'b1;
        repeat (3) cycle();
        rst = 1'b0;
        repeat (2) cycle();
    endtask

    task automatic wait_irq(input string tag);
        int n = 0;
        while (irq !== 1'b1 && n < 60) begin
            cycle();
            n++;
        end
        check_eq(tag, 64'(irq), 64'd1);
    endtask

    task automatic ack_one(input int exp_id, input string tag);
        wait_irq(tag);
        check_eq(tag, 64'(irq_id), 64'(exp_id));
        ack = 1'b1;
        cycle();
        ack = 1'b0;
    endtask

    initial begin
        #1_000_000;
        $display("FAIL watchdog: simulation did not finish");
        $fatal(1);
    end

    initial begin
        gpio_in = '0; gpio_dir = '0; int_en = '0; int_type = '0;
        filt_div = '0; pclr = '0; ack = 1'b0; rst = 1'b1;
        model_reset();

        // reset state and latency
        repeat (3) cycle();
        check_eq("rst_irq", 64'(irq), 64'd0);
        check_eq("rst_pend", 64'(pend), 64'd0);
        check_eq("rst_sync", 64'(sync), 64'd0);
        rst = 1'b0;
        repeat (2) cycle();
        int_en[4] = 1'b1;
        gpio_in[4] = 1'b1;
        repeat (4) cycle();
        check_eq("lat_pend_e4", 64'(pend[4]), 64'd0);
        cycle();
        check_eq("lat_pend_e5", 64'(pend[4]), 64'd1);
        check_eq("lat_irq_e5", 64'(irq), 64'd0);
        cycle();
        check_eq("lat_irq_e6", 64'(irq), 64'd1);
        check_eq("lat_id_e6", 64'(irq_id), 64'd4);
        ack = 1'b1;
        cycle();
        ack = 1'b0;
        check_eq("ack_pend_clr", 64'(pend[4]), 64'd0);
        check_eq("ack_irq_low1", 64'(irq), 64'd0);
        cycle();
        check_eq("ack_irq_low2", 64'(irq), 64'd0);

        // glitch filter
        do_reset();
        filt_div = 16'd3;
        int_en[2] = 1'b1;
        gpio_in[2] = 1'b1;
        repeat (3) cycle();
        gpio_in[2] = 1'b0;
        repeat (16) cycle();
        check_eq("glitch_pend", 64'(pend[2]), 64'd0);
        check_eq("glitch_sync", 64'(sync[2]), 64'd0);
        gpio_in[2] = 1'b1;
        repeat (12) cycle();
        check_eq("held_sync", 64'(sync[2]), 64'd1);
        gpio_in[2] = 1'b0;
        repeat (2) cycle();
        check_eq("held_pend", 64'(pend[2]), 64'd1);
        ack_one(2, "held_ack");

        // round robin
        do_reset();
        int_en = 32'h4000_0022;
        gpio_in = 32'h4000_0022;
        ack_one(1, "rr_first");
        ack_one(5, "rr_second");
        gpio_in[1] = 1'b0; gpio_in[5] = 1'b0;
        repeat (6) cycle();
        gpio_in[1] = 1'b1; gpio_in[5] = 1'b1;
        repeat (8) cycle();
        ack_one(30, "rr_wrap30");
        ack_one(1, "rr_wrap1");
        ack_one(5, "rr_wrap5");

        // direction and event types
        do_reset();
        gpio_dir[7] = 1'b1;
        int_en = 32'h0000_0780;
        int_type[17:16] = 2'b01;
        int_type[19:18] = 2'b10;
        int_type[21:20] = 2'b11;
        for (int i = 0; i < 4; i++) begin
            gpio_in[7] = ~gpio_in[7];
            repeat (6) cycle();
        end
        check_eq("dir_pend7", 64'(pend[7]), 64'd0);
        check_eq("dir_no_irq", 64'(irq), 64'd0);
        gpio_in[8] = 1'b1;
        repeat (8) cycle();
        check_eq("fall_no_rise", 64'(pend[8]), 64'd0);
        gpio_in[8] = 1'b0;
        repeat (6) cycle();
        check_eq("fall_pend", 64'(pend[8]), 64'd1);
        ack_one(8, "fall_ack");
        gpio_in[9] = 1'b1;
        ack_one(9, "both_rise");
        gpio_in[9] = 1'b0;
        ack_one(9, "both_fall");
        gpio_in[10] = 1'b1;
        ack_one(10, "level_a");
        ack_one(10, "level_b");
        gpio_in[10] = 1'b0;
        repeat (10) cycle();
        ack_one(10, "level_last");
        repeat (6) cycle();
        check_eq("level_done_irq", 64'(irq), 64'd0);
        check_eq("level_done_pend", 64'(pend[10]), 64'd0);

        // clear races
        do_reset();
        int_en[3] = 1'b1; int_en[6] = 1'b1;
        gpio_in[3] = 1'b1;
        wait_irq("clr_wait");
        check_eq("clr_id", 64'(irq_id), 64'd3);
        pclr[3] = 1'b1;
        cycle();
        pclr[3] = 1'b0;
        check_eq("clr_pend", 64'(pend[3]), 64'd0);
        check_eq("clr_irq_held", 64'(irq), 64'd1);
        cycle();
        check_eq("clr_withdraw", 64'(irq), 64'd0);
        gpio_in[3] = 1'b0;
        repeat (6) cycle();
        gpio_in[3] = 1'b1; gpio_in[6] = 1'b1;
        ack_one(3, "clr_ptr_kept");
        ack_one(6, "clr_next6");
        int_type[7:6] = 2'b10;
        gpio_in[3] = 1'b0;
        wait_irq("race_wait");
        check_eq("race_id", 64'(irq_id), 64'd3);
        gpio_in[3] = 1'b1;
        repeat (4) cycle();
        ack = 1'b1;
        cycle();
        ack = 1'b0;
        check_eq("race_set_wins", 64'(pend[3]), 64'd1);
        ack_one(3, "race_reserve");

        // asynchronous reset during a request
        do_reset();
        int_en[4] = 1'b1;
        gpio_in[4] = 1'b1;
        wait_irq("arst_wait");
        #3;
        rst = 1'b1;
        #1;
        check_eq("arst_irq", 64'(irq), 64'd0);
        check_eq("arst_pend", 64'(pend), 64'd0);
        gpio_in = '0;
        repeat (2) cycle();
        rst = 1'b0;
        repeat (8) cycle();
        check_eq("arst_idle", 64'(irq), 64'd0);

        // randomized traffic
        do_reset();
        for (int c = 0; c < 1200; c++) begin
            if (c % 100 == 0) begin
                gpio_dir = $urandom & $urandom;
                int_en   = $urandom;
                int_type = {$urandom, $urandom};
                filt_div = DIVW'($urandom_range(3, 0));
            end
            gpio_in = gpio_in ^ ($urandom & $urandom & $urandom & $urandom);
            pclr    = ($urandom_range(15, 0) == 0) ? (32'd1 << $urandom_range(31, 0)) : 32'd0;
            ack     = irq && ($urandom_range(1, 0) == 1);
            cycle();
        end
        ack = 1'b0;
        pclr = '0;

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
